// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder: default field widths,
// frame length and the frame-phase state encoding.
package spi_pkg;

  localparam int DEF_CMD_W  = 8;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;
  localparam int FRAME_BITS = DEF_CMD_W + DEF_ADDR_W + DEF_DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection
// from the last two synchronised samples. Reset loads the pin's idle level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  // NOTE: clocked state uses non-blocking assignments so every flop in the
  // chain samples its predecessor's old value; blocking here would collapse
  // the synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder for the command/address/data frame, oversampled in
// the clk domain. Optional frame_err output: define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int CMD_W       = DEF_CMD_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] ext_data_in,
  output logic              addr_valid,
  output logic              rx_valid,
  output logic [CMD_W-1:0]  rx_command,
  output logic [ADDR_W-1:0] rx_address,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CNT_W = $clog2(max3(CMD_W, ADDR_W, DATA_W));

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CMD_W-1:0]   cmd_sh;
  logic [ADDR_W-1:0]  addr_sh;
  logic [DATA_W-1:0]  data_sh;
  logic [DATA_W-1:0]  tx_sh;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Same depth as the sck chain so mosi is sampled in step with sck_rise.
  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      cmd_sh     <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      tx_sh      <= '0;
      miso       <= 1'b0;
      addr_valid <= 1'b0;
      rx_valid   <= 1'b0;
      rx_command <= '0;
      rx_address <= '0;
      rx_data    <= '0;
      busy       <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      addr_valid <= 1'b0;
      rx_valid   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
      if (cs_rise) begin
        // Deselect always wins; an incomplete frame is dropped here.
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
        busy    <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err <= (state == CMD) || (state == ADDR) || (state == DATA);
`endif
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_sh <= {cmd_sh[CMD_W-2:0], mosi_s};
              if (bit_cnt == CNT_W'(CMD_W - 1)) begin
                state   <= ADDR;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              addr_sh <= {addr_sh[ADDR_W-2:0], mosi_s};
              if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                state      <= DATA;
                bit_cnt    <= '0;
                addr_valid <= 1'b1;
                rx_command <= cmd_sh;
                rx_address <= {addr_sh[ADDR_W-2:0], mosi_s};
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            // Loaded while addr_valid is visible so ext_data_in can be
            // decoded from the freshly updated rx_command/rx_address.
            if (addr_valid) tx_sh <= ext_data_in;
            if (sck_fall) begin
              miso  <= tx_sh[DATA_W-1];
              tx_sh <= tx_sh << 1;
            end
            if (sck_rise) begin
              data_sh <= {data_sh[DATA_W-2:0], mosi_s};
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                state    <= DONE;
                bit_cnt  <= '0;
                rx_valid <= 1'b1;
                rx_data  <= {data_sh[DATA_W-2:0], mosi_s};
                miso     <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          DONE: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (sck_rise) frame_err <= 1'b1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
